// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the frame state encoding, the default line/frame constants and a
// counter-width helper.
package uart_pkg;

    // Frame states. The encoding is shared with the receiver.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Default line settings.
    localparam int UART_SYS_CLK_FREQ = 50_000_000;
    localparam int UART_BAUD_RATE    = 9600;
    localparam int UART_DATA_SIZE    = 8;
    localparam int UART_STOP_BITS    = 2;

    // Width of a counter that must reach max_val. The result is at least one
    // bit, so a counter whose maximum is 0 still has a legal declaration.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART.
// Counts 0 .. CLKS_PER_BIT-1 and asserts tick in the last cycle of each
// period. restart forces the count back to 0 so that a new frame's first bit
// gets a full period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_SYS_CLK_FREQ / UART_BAUD_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W   = cnt_width(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Bit-period count: wraps at CNT_MAX, forced to 0 on restart or reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == CNT_MAX)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter.
// Frame: start bit (0), DATA_SIZE data bits LSB first, an optional even
// parity bit, then STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks.
// Build option: define UART_TX_PARITY_EN to include the parity bit. The
// receiver always expects parity, so define UART_TX_PARITY_EN when this
// block drives it.
//
// Handshake: a frame is accepted in any cycle where tx_start=1, rst=1 and the
// FSM is IDLE (tx_busy=0). data_in is captured in that cycle. tx_start is
// ignored in every other cycle; there is no queue. tx_busy rises the cycle
// after acceptance. tx_done pulses in the last cycle of the final stop bit.
// tx_busy falls the cycle after that pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_SIZE    = UART_DATA_SIZE,
    parameter int STOP_BITS    = UART_STOP_BITS,
    parameter int SYS_CLK_FREQ = UART_SYS_CLK_FREQ,
    parameter int BAUD_RATE    = UART_BAUD_RATE,
    parameter int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 tx_start,
    output logic                 data_tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output uart_state_e          dbg_state
);

    localparam int               BIT_W     = cnt_width(DATA_SIZE - 1);
    localparam int               STOP_W    = cnt_width(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_SIZE - 1);
    localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

    uart_state_e           state_q,    state_n;
    logic [DATA_SIZE-1:0]  shift_q,    shift_n;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_n;
    logic [STOP_W-1:0]     stop_cnt_q, stop_cnt_n;
    logic                  data_tx_q,  data_tx_n;
    logic                  busy_q,     busy_n;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q,   parity_n;
`endif
    logic                  restart;
    logic                  tick;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // State register plus the registered line, busy flag and frame counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            data_tx_q  <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            bit_cnt_q  <= bit_cnt_n;
            stop_cnt_q <= stop_cnt_n;
            data_tx_q  <= data_tx_n;
            busy_q     <= busy_n;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_n;
`endif
        end
    end

    // Next-state logic. data_tx_n is the value of the next bit, so the line
    // changes on the same edge as the state.
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        bit_cnt_n  = bit_cnt_q;
        stop_cnt_n = stop_cnt_q;
        data_tx_n  = data_tx_q;
        busy_n     = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity_q;
`endif
        restart    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_tx_n = 1'b1;
                busy_n    = 1'b0;
                if (tx_start) begin
                    state_n    = ST_START;
                    shift_n    = data_in;
                    bit_cnt_n  = '0;
                    stop_cnt_n = '0;
                    data_tx_n  = 1'b0;
                    busy_n     = 1'b1;
                    restart    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_n   = ^data_in;
`endif
                end
            end

            ST_START: begin
                if (tick) begin
                    state_n   = ST_DATA;
                    data_tx_n = shift_q[0];
                    shift_n   = shift_q >> 1;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_n   = ST_PARITY;
                        data_tx_n = parity_q;
`else
                        state_n   = ST_STOP;
                        data_tx_n = 1'b1;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt_q + 1'b1;
                        data_tx_n = shift_q[0];
                        shift_n   = shift_q >> 1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_n   = ST_STOP;
                    data_tx_n = 1'b1;
                end
            end
`endif

            ST_STOP: begin
                data_tx_n = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        stop_cnt_n = stop_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_n   = ST_IDLE;
                data_tx_n = 1'b1;
                busy_n    = 1'b0;
            end
        endcase
    end

    // tx_done is decoded from registered state in the last cycle of the final
    // stop bit. It is gated by rst so that a reset never produces a pulse.
    assign tx_done   = rst && (state_q == ST_STOP) && tick && (stop_cnt_q == LAST_STOP);
    assign data_tx   = data_tx_q;
    assign tx_busy   = busy_q;
    assign dbg_state = state_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: data bits per frame; legal range 5 to 9.
REQ-002 SHALL have parameter STOP_BITS, default 2: stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have parameter SYS_CLK_FREQ, default 50000000: clk frequency in Hz.
REQ-004 SHALL have parameter BAUD_RATE, default 9600: line bit rate.
REQ-005 SHALL have parameter CLKS_PER_BIT, default SYS_CLK_FREQ / BAUD_RATE: clk cycles per bit; minimum 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port data_in, input, DATA_SIZE bits: byte to send; sampled only on frame acceptance.
REQ-009 SHALL have port tx_start, input, 1 bit: request to send data_in.
REQ-010 SHALL have port data_tx, output, 1 bit: serial line; idle level is high.
REQ-011 SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-014 SHALL accept a frame only when tx_start=1 in a cycle where the state is IDLE, capturing data_in into a shift register in that cycle.
REQ-015 SHALL ignore tx_start while tx_busy=1, with no queuing and no corruption of the frame in flight.
REQ-016 SHALL make tx_busy and data_tx registered, so that acceptance in cycle N gives tx_busy=1 and data_tx=0 (start bit) from cycle N+1.
REQ-017 SHALL restart the bit-period counter at acceptance, holding each bit on data_tx for exactly CLKS_PER_BIT cycles.
REQ-018 SHALL send the bits in this order: start (0); DATA_SIZE data bits, LSB first; the optional parity bit; STOP_BITS stop bits (1).
REQ-019 SHALL set the parity bit to the XOR of all captured data bits (even parity), matching the parity check in the receiver.
REQ-020 SHALL follow these transitions, each taken at the end of a bit period:
- IDLE->START on acceptance.
- START->DATA.
- DATA->DATA until bit DATA_SIZE-1 is sent, then DATA->PARITY, or DATA->STOP when parity is compiled out.
- PARITY->STOP.
- STOP->IDLE after STOP_BITS periods.
REQ-021 SHALL take a total frame time of (1 + DATA_SIZE + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 when parity is compiled in and P=0 otherwise.
REQ-022 SHALL pulse tx_done for one cycle in the last cycle of the final stop bit, and deassert tx_busy in the following cycle.
REQ-023 SHALL allow back-to-back frames: tx_start in the first IDLE cycle starts the next start bit one cycle later, so the line is high for exactly 1 cycle between frames.
REQ-024 SHALL hold data_tx=1 in IDLE.
REQ-025 SHALL have data_in changes after acceptance no effect on the frame in flight.
REQ-026 SHALL size the counters so that the bit-period counter covers CLKS_PER_BIT-1, the data bit counter covers DATA_SIZE-1, and the stop bit counter covers STOP_BITS-1, with no wrap-around inside a frame.

Reset
REQ-027 SHALL, while rst=0 at a rising clk edge, set state=IDLE, data_tx=1, tx_busy=0, tx_done=0, and clear all counters and the shift register.
REQ-028 SHALL, when reset is applied mid-frame, abort the frame: data_tx=1 from the cycle after the reset edge, no tx_done pulse, and no resumption after reset releases.
REQ-029 SHALL ignore tx_start in any cycle where rst=0.

Configuration
REQ-030 SHALL use the macro UART_TX_PARITY_EN to select parity.
REQ-031 SHALL, when UART_TX_PARITY_EN is defined, compile in the PARITY state and its bit per REQ-019.
REQ-032 SHALL, when UART_TX_PARITY_EN is not defined, never enter PARITY and go from DATA directly to STOP.
REQ-033 SHALL keep the default build (macro defined) compatible with the existing receiver, which always expects a parity bit.

Structure
REQ-034 SHALL place the state enum typedef and the default baud/frame constants in the shared package uart_pkg, used by both transmitter and receiver.
REQ-035 SHALL place the bit-period counter in one sub-module, uart_baud_gen (parameter CLKS_PER_BIT, inputs clk, rst and a restart signal, output a one-cycle tick at the end of each period); uart_tx instantiates it.

Verification
REQ-036 SHALL cover single frame: CLKS_PER_BIT=16, DATA_SIZE=8, STOP_BITS=2, parity on, data_in=8'hA5 -> line 0,1,0,1,0,0,1,0,1,0,1,1, each bit 16 cycles, tx_done at cycle 192 after acceptance.
REQ-037 SHALL cover parity: data_in=8'h07 gives parity 1 and 8'h03 gives parity 0; compiled without the macro, data_in=8'hA5 with STOP_BITS=1 gives a 10-bit frame of 160 cycles.
REQ-038 SHALL cover busy ignore: tx_start pulsed with 8'h55 at cycle 50 of an 8'hA5 frame -> only 8'hA5 sent, one tx_done pulse.
REQ-039 SHALL cover back-to-back: tx_start held high with 8'h01 then 8'hFE -> the second start bit begins 1 cycle after the first tx_busy drop.
REQ-040 SHALL cover mid-frame reset: rst=0 at cycle 70 of a frame -> data_tx=1 and tx_busy=0 the next cycle, no tx_done, and the line stays idle after release.
REQ-041 SHALL cover loopback: data_tx wired to the receiver, all 256 values of data_in -> data_out equals data_in and pkt_drop stays 0.
